// File: rtl/moxie_wb_pkg.sv
// moxie_wb_pkg
//   Shared definitions for the moxie Wishbone arbiter slice.
//   - default bus widths and watchdog limit
//   - grant index constants (bit positions in grant_o, last_grant encoding)
//   - FSM state encoding
package moxie_wb_pkg;

    localparam int DEFAULT_AW      = 32;
    localparam int DEFAULT_DW      = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    // Grant indices: bit position in grant_o, and the value held in last_grant.
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

endpackage

// File: rtl/moxie_wb_watchdog.sv
// moxie_wb_watchdog
//   Comparator half of the bus watchdog. Flags the cycle that would be the
//   limit-th consecutive stalled strobe, so the arbiter can turn it into an
//   error instead of letting the slave hang the master.
// Ports:
//   count   in  CW    stalled cycles seen before this one
//   limit   in  CW+1  number of stalled cycles that triggers a timeout
//   stb     in  1     owner's strobe before any timeout masking
//   ack     in  1     slave ack
//   err     in  1     slave error
//   timeout out 1     one-cycle timeout pulse
module moxie_wb_watchdog #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] count,
    input  logic [CW:0]   limit,
    input  logic          stb,
    input  logic          ack,
    input  logic          err,
    output logic          timeout
);

    logic [CW:0] count_incl;

    // Count including the current stalled cycle; widened so it cannot wrap.
    assign count_incl = {1'b0, count} + {{CW{1'b0}}, 1'b1};
    assign timeout    = stb && !ack && !err && (count_incl == limit);

endmodule

// File: rtl/moxie_wb_arbiter.sv
// moxie_wb_arbiter
//   Two-master (instruction I, data D) to one-slave Wishbone arbiter.
//   Round-robin under contention, no preemption of a granted cycle, and a
//   watchdog that converts a hung slave into an error for the owner.
// Ports:
//   clk_i, rst_i                clock, asynchronous active-low reset
//   wb_I_* / wb_D_*             master-side ports (adr/dat/sel/we/cyc/stb in,
//                               dat/ack/err out)
//   wb_adr_o..wb_stb_o          slave-side request, muxed from the owner
//   wb_dat_i, wb_ack_i, wb_err_i slave response
//   grant_o                     {D,I} one-hot current owner (00 when idle)
//
// Handshake: a master requests by raising cyc; it owns the bus from the
// cycle after the grant registers until the edge where it samples its own
// cyc low. stb/ack/err pass through unchanged for the owner; the non-owner
// sees ack/err held at 0.
module moxie_wb_arbiter
    import moxie_wb_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic [AW-1:0]   wb_I_adr_i,
    input  logic [DW-1:0]   wb_I_dat_i,
    input  logic [DW/8-1:0] wb_I_sel_i,
    input  logic            wb_I_we_i,
    input  logic            wb_I_cyc_i,
    input  logic            wb_I_stb_i,
    output logic [DW-1:0]   wb_I_dat_o,
    output logic            wb_I_ack_o,
    output logic            wb_I_err_o,

    input  logic [AW-1:0]   wb_D_adr_i,
    input  logic [DW-1:0]   wb_D_dat_i,
    input  logic [DW/8-1:0] wb_D_sel_i,
    input  logic            wb_D_we_i,
    input  logic            wb_D_cyc_i,
    input  logic            wb_D_stb_i,
    output logic [DW-1:0]   wb_D_dat_o,
    output logic            wb_D_ack_o,
    output logic            wb_D_err_o,

    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,

    output logic [1:0]      grant_o
);

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 1'(GNT_I) or 1'(GNT_D)
    logic   own_i, own_d;
    logic   stb_raw;
    logic   timeout;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'(GNT_I);    // D wins the first contention
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_I_cyc_i && wb_D_cyc_i)
                    state_d = (last_grant_q == 1'(GNT_D)) ? ST_GNT_I : ST_GNT_D;
                else if (wb_I_cyc_i)
                    state_d = ST_GNT_I;
                else if (wb_D_cyc_i)
                    state_d = ST_GNT_D;
            end
            ST_GNT_I: begin
                if (!wb_I_cyc_i) begin
                    last_grant_d = 1'(GNT_I);
                    // Hand straight over to a waiting D, no idle bubble.
                    state_d = wb_D_cyc_i ? ST_GNT_D : ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (!wb_D_cyc_i) begin
                    last_grant_d = 1'(GNT_D);
                    state_d = wb_I_cyc_i ? ST_GNT_I : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic: slave-side request mux (all zero when idle)
    // ---------------------------------------------------------------
    assign own_i = (state_q == ST_GNT_I);
    assign own_d = (state_q == ST_GNT_D);

    always_comb begin
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        wb_we_o  = 1'b0;
        wb_cyc_o = 1'b0;
        stb_raw  = 1'b0;
        grant_o  = 2'b00;
        if (own_i) begin
            wb_adr_o       = wb_I_adr_i;
            wb_dat_o       = wb_I_dat_i;
            wb_sel_o       = wb_I_sel_i;
            wb_we_o        = wb_I_we_i;
            wb_cyc_o       = wb_I_cyc_i;
            stb_raw        = wb_I_stb_i;
            grant_o[GNT_I] = 1'b1;
        end else if (own_d) begin
            wb_adr_o       = wb_D_adr_i;
            wb_dat_o       = wb_D_dat_i;
            wb_sel_o       = wb_D_sel_i;
            wb_we_o        = wb_D_we_i;
            wb_cyc_o       = wb_D_cyc_i;
            stb_raw        = wb_D_stb_i;
            grant_o[GNT_D] = 1'b1;
        end
    end

    // A timed-out strobe is withdrawn from the slave for that cycle.
    assign wb_stb_o = stb_raw && !timeout;

    // Response routing: only the owner sees ack/err; read data is broadcast
    // but held at 0 during reset so every output is quiet while rst_i is low.
    assign wb_I_ack_o = own_i && wb_ack_i;
    assign wb_D_ack_o = own_d && wb_ack_i;
    assign wb_I_err_o = own_i && (wb_err_i || timeout);
    assign wb_D_err_o = own_d && (wb_err_i || timeout);
    assign wb_I_dat_o = rst_i ? wb_dat_i : '0;
    assign wb_D_dat_o = rst_i ? wb_dat_i : '0;

    // ---------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------
    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] wd_cnt_q;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i)
                    wd_cnt_q <= '0;
                else if (timeout || !stb_raw || wb_ack_i || wb_err_i)
                    wd_cnt_q <= '0;
                else
                    wd_cnt_q <= wd_cnt_q + 1'b1;
            end

            moxie_wb_watchdog #(
                .CW(CW)
            ) u_watchdog (
                .count   (wd_cnt_q),
                .limit   ((CW+1)'(TIMEOUT)),
                .stb     (stb_raw),
                .ack     (wb_ack_i),
                .err     (wb_err_i),
                .timeout (timeout)
            );
        end else begin : g_no_wd
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
module tb_moxie_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk_i;
    logic            rst_i;
    logic [AW-1:0]   wb_I_adr_i, wb_D_adr_i, wb_adr_o;
    logic [DW-1:0]   wb_I_dat_i, wb_D_dat_i, wb_I_dat_o, wb_D_dat_o, wb_dat_o, wb_dat_i;
    logic [DW/8-1:0] wb_I_sel_i, wb_D_sel_i, wb_sel_o;
    logic            wb_I_we_i, wb_I_cyc_i, wb_I_stb_i, wb_I_ack_o, wb_I_err_o;
    logic            wb_D_we_i, wb_D_cyc_i, wb_D_stb_i, wb_D_ack_o, wb_D_err_o;
    logic            wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic [1:0]      grant_o;

    int n_vec = 0;
    int n_err = 0;

    moxie_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_I_adr_i(wb_I_adr_i), .wb_I_dat_i(wb_I_dat_i), .wb_I_sel_i(wb_I_sel_i),
        .wb_I_we_i(wb_I_we_i), .wb_I_cyc_i(wb_I_cyc_i), .wb_I_stb_i(wb_I_stb_i),
        .wb_I_dat_o(wb_I_dat_o), .wb_I_ack_o(wb_I_ack_o), .wb_I_err_o(wb_I_err_o),
        .wb_D_adr_i(wb_D_adr_i), .wb_D_dat_i(wb_D_dat_i), .wb_D_sel_i(wb_D_sel_i),
        .wb_D_we_i(wb_D_we_i), .wb_D_cyc_i(wb_D_cyc_i), .wb_D_stb_i(wb_D_stb_i),
        .wb_D_dat_o(wb_D_dat_o), .wb_D_ack_o(wb_D_ack_o), .wb_D_err_o(wb_D_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .grant_o(grant_o)
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change only on the falling edge; outputs are checked 1 ns later.
    task automatic idle_inputs();
        wb_I_adr_i = '0; wb_I_dat_i = '0; wb_I_sel_i = '0;
        wb_I_we_i = 1'b0; wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0;
        wb_D_adr_i = '0; wb_D_dat_i = '0; wb_D_sel_i = '0;
        wb_D_we_i = 1'b0; wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    endtask

    task automatic drive_i(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [3:0] sel, input logic we, input logic on);
        wb_I_adr_i = adr; wb_I_dat_i = dat; wb_I_sel_i = sel;
        wb_I_we_i = we; wb_I_cyc_i = on; wb_I_stb_i = on;
    endtask

    task automatic drive_d(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [3:0] sel, input logic we, input logic on);
        wb_D_adr_i = adr; wb_D_dat_i = dat; wb_D_sel_i = sel;
        wb_D_we_i = we; wb_D_cyc_i = on; wb_D_stb_i = on;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle_inputs();
        // Requests and slave activity during reset must not leak through.
        drive_i(32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b1);
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_i);
        #1;
        if (grant_o !== 2'b00) begin $display("FAIL rst_grant: got %b want 00", grant_o); n_err++; end n_vec++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin $display("FAIL rst_cyc_stb: got %b%b want 00", wb_cyc_o, wb_stb_o); n_err++; end n_vec++;
        if (wb_I_ack_o !== 1'b0 || wb_I_dat_o !== 32'h0) begin $display("FAIL rst_I_resp: got ack %b dat %h want 0 0", wb_I_ack_o, wb_I_dat_o); n_err++; end n_vec++;
        if (wb_adr_o !== 32'h0) begin $display("FAIL rst_adr: got %h want 0", wb_adr_o); n_err++; end n_vec++;
        idle_inputs();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_contention();
        drive_i(32'hA000_0000, 32'h0, 4'hF, 1'b0, 1'b1);
        drive_d(32'hD000_0000, 32'h0, 4'hF, 1'b0, 1'b1);
        #1;
        if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0) begin $display("FAIL cont_latency: got grant %b cyc %b want 00 0", grant_o, wb_cyc_o); n_err++; end n_vec++;
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10) begin $display("FAIL cont_first_d: got %b want 10", grant_o); n_err++; end n_vec++;
        if (wb_adr_o !== 32'hD000_0000) begin $display("FAIL cont_adr_d: got %h want d0000000", wb_adr_o); n_err++; end n_vec++;
        // D takes its ack and drops cyc in the same cycle.
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
        drive_d(32'hD000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
        #1;
        if (wb_D_ack_o !== 1'b1 || wb_I_ack_o !== 1'b0) begin $display("FAIL cont_ack_route: got D %b I %b want 1 0", wb_D_ack_o, wb_I_ack_o); n_err++; end n_vec++;
        @(negedge clk_i);
        wb_ack_i = 1'b0; #1;
        if (grant_o !== 2'b01) begin $display("FAIL cont_b2b_i: got %b want 01", grant_o); n_err++; end n_vec++;
        if (wb_adr_o !== 32'hA000_0000) begin $display("FAIL cont_adr_i: got %h want a0000000", wb_adr_o); n_err++; end n_vec++;
        wb_ack_i = 1'b1;
        drive_i(32'hA000_0000, 32'h0, 4'hF, 1'b0, 1'b0);
        #1;
        if (wb_I_ack_o !== 1'b1 || wb_D_ack_o !== 1'b0) begin $display("FAIL cont_ack_i: got I %b D %b want 1 0", wb_I_ack_o, wb_D_ack_o); n_err++; end n_vec++;
        @(negedge clk_i);
        wb_ack_i = 1'b0; #1;
        if (grant_o !== 2'b00) begin $display("FAIL cont_idle: got %b want 00", grant_o); n_err++; end n_vec++;
        // last grant was I, so a fresh contention goes to D.
        drive_i(32'hA000_0004, 32'h0, 4'hF, 1'b0, 1'b1);
        drive_d(32'hD000_0004, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10) begin $display("FAIL cont_repeat_d: got %b want 10", grant_o); n_err++; end n_vec++;
        idle_inputs();
        @(negedge clk_i); #1;
        if (grant_o !== 2'b00) begin $display("FAIL cont_release: got %b want 00", grant_o); n_err++; end n_vec++;
    endtask

    task automatic test_single_read();
        @(negedge clk_i);
        drive_i(32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b1);
        #1;
        if (wb_cyc_o !== 1'b0) begin $display("FAIL rd_latency: got cyc %b want 0", wb_cyc_o); n_err++; end n_vec++;
        @(negedge clk_i); #1;
        if (wb_adr_o !== 32'h0000_1000 || wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1) begin $display("FAIL rd_req: got adr %h stb %b cyc %b want 00001000 1 1", wb_adr_o, wb_stb_o, wb_cyc_o); n_err++; end n_vec++;
        if (wb_I_ack_o !== 1'b0 || wb_D_ack_o !== 1'b0) begin $display("FAIL rd_wait_ack: got I %b D %b want 0 0", wb_I_ack_o, wb_D_ack_o); n_err++; end n_vec++;
        @(negedge clk_i);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; #1;
        if (wb_I_ack_o !== 1'b1 || wb_I_dat_o !== 32'hDEAD_BEEF) begin $display("FAIL rd_resp: got ack %b dat %h want 1 deadbeef", wb_I_ack_o, wb_I_dat_o); n_err++; end n_vec++;
        if (wb_D_ack_o !== 1'b0 || wb_D_dat_o !== 32'hDEAD_BEEF) begin $display("FAIL rd_d_side: got ack %b dat %h want 0 deadbeef", wb_D_ack_o, wb_D_dat_o); n_err++; end n_vec++;
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        drive_i(32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b0);
        #1;
        if (grant_o !== 2'b01 || wb_cyc_o !== 1'b0) begin $display("FAIL rd_drop: got grant %b cyc %b want 01 0", grant_o, wb_cyc_o); n_err++; end n_vec++;
        @(negedge clk_i); #1;
        if (grant_o !== 2'b00) begin $display("FAIL rd_release: got %b want 00", grant_o); n_err++; end n_vec++;
    endtask

    task automatic test_back_to_back();
        drive_d(32'hD000_0100, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10) begin $display("FAIL b2b_d_own: got %b want 10", grant_o); n_err++; end n_vec++;
        drive_i(32'hA000_0100, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10 || wb_I_ack_o !== 1'b0) begin $display("FAIL b2b_no_preempt: got grant %b I_ack %b want 10 0", grant_o, wb_I_ack_o); n_err++; end n_vec++;
        drive_d(32'hD000_0100, 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk_i);
        drive_d(32'hD000_0104, 32'h0, 4'hF, 1'b0, 1'b1);
        #1;
        if (grant_o !== 2'b01 || wb_adr_o !== 32'hA000_0100) begin $display("FAIL b2b_i_next: got grant %b adr %h want 01 a0000100", grant_o, wb_adr_o); n_err++; end n_vec++;
        @(negedge clk_i); #1;
        if (grant_o !== 2'b01) begin $display("FAIL b2b_i_hold: got %b want 01", grant_o); n_err++; end n_vec++;
        drive_i(32'hA000_0100, 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10 || wb_adr_o !== 32'hD000_0104) begin $display("FAIL b2b_d_back: got grant %b adr %h want 10 d0000104", grant_o, wb_adr_o); n_err++; end n_vec++;
        idle_inputs();
        @(negedge clk_i); #1;
        if (grant_o !== 2'b00) begin $display("FAIL b2b_release: got %b want 00", grant_o); n_err++; end n_vec++;
    endtask

    task automatic test_watchdog();
        drive_d(32'hD000_0200, 32'h0, 4'hF, 1'b0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i); #1;
            if (wb_D_err_o !== 1'b0 || wb_stb_o !== 1'b1) begin $display("FAIL wd_stall%0d: got err %b stb %b want 0 1", c, wb_D_err_o, wb_stb_o); n_err++; end n_vec++;
        end
        @(negedge clk_i); #1;
        if (wb_D_err_o !== 1'b1 || wb_stb_o !== 1'b0) begin $display("FAIL wd_fire: got err %b stb %b want 1 0", wb_D_err_o, wb_stb_o); n_err++; end n_vec++;
        if (wb_I_err_o !== 1'b0 || grant_o !== 2'b10 || wb_cyc_o !== 1'b1) begin $display("FAIL wd_fire_side: got I_err %b grant %b cyc %b want 0 10 1", wb_I_err_o, grant_o, wb_cyc_o); n_err++; end n_vec++;
        @(negedge clk_i); #1;
        if (wb_D_err_o !== 1'b0 || wb_stb_o !== 1'b1 || grant_o !== 2'b10) begin $display("FAIL wd_one_shot: got err %b stb %b grant %b want 0 1 10", wb_D_err_o, wb_stb_o, grant_o); n_err++; end n_vec++;
        idle_inputs();
        @(negedge clk_i); #1;
        if (grant_o !== 2'b00) begin $display("FAIL wd_release: got %b want 00", grant_o); n_err++; end n_vec++;
    endtask

    task automatic test_slave_error();
        drive_i(32'h0000_2000, 32'h1234_5678, 4'b0011, 1'b1, 1'b1);
        @(negedge clk_i); #1;
        if (wb_we_o !== 1'b1 || wb_sel_o !== 4'b0011 || wb_dat_o !== 32'h1234_5678) begin $display("FAIL err_req: got we %b sel %b dat %h want 1 0011 12345678", wb_we_o, wb_sel_o, wb_dat_o); n_err++; end n_vec++;
        @(negedge clk_i);
        wb_err_i = 1'b1; #1;
        if (wb_I_err_o !== 1'b1 || wb_I_ack_o !== 1'b0 || wb_D_err_o !== 1'b0) begin $display("FAIL err_route: got I_err %b I_ack %b D_err %b want 1 0 0", wb_I_err_o, wb_I_ack_o, wb_D_err_o); n_err++; end n_vec++;
        // Counter must restart after the error: three more stalls stay quiet.
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            wb_err_i = 1'b0; #1;
            if (wb_I_err_o !== 1'b0 || wb_stb_o !== 1'b1) begin $display("FAIL err_wd_clear%0d: got err %b stb %b want 0 1", c, wb_I_err_o, wb_stb_o); n_err++; end n_vec++;
        end
        idle_inputs();
        @(negedge clk_i); #1;
        if (grant_o !== 2'b00) begin $display("FAIL err_release: got %b want 00", grant_o); n_err++; end n_vec++;
    endtask

    task automatic test_reset_mid();
        drive_d(32'hD000_0300, 32'h0, 4'hF, 1'b0, 1'b1);
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10 || wb_stb_o !== 1'b1) begin $display("FAIL rstm_pre: got grant %b stb %b want 10 1", grant_o, wb_stb_o); n_err++; end n_vec++;
        #2 rst_i = 1'b0;
        #1;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || grant_o !== 2'b00) begin $display("FAIL rstm_async: got cyc %b stb %b grant %b want 0 0 00", wb_cyc_o, wb_stb_o, grant_o); n_err++; end n_vec++;
        @(negedge clk_i);
        rst_i = 1'b1; #1;
        if (grant_o !== 2'b00 || wb_cyc_o !== 1'b0) begin $display("FAIL rstm_idle: got grant %b cyc %b want 00 0", grant_o, wb_cyc_o); n_err++; end n_vec++;
        @(negedge clk_i); #1;
        if (grant_o !== 2'b10) begin $display("FAIL rstm_regrant: got %b want 10", grant_o); n_err++; end n_vec++;
        idle_inputs();
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_back_to_back();
        test_watchdog();
        test_slave_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
